// File: rtl/tm_display_pkg.sv
// Shared definitions for the Turing-machine display driver: digit index type,
// active-low seven-segment glyphs and the tape population-count helper.
package tm_display_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t DIGIT_LAST = 2'd3;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_D     = 7'b0100001;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

  // Number of set cells in the 11-cell tape window; 11 fits in 4 bits.
  function automatic logic [3:0] popcount11(input logic [10:0] bits);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 11; i++) begin
      sum = sum + {3'b000, bits[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/tm_display_if.sv
// Signal bundle between the Turing-machine core and its display driver.
// master = core side (drives tape/state), slave = display side.
interface tm_display_if;
  logic [10:0] display_out;
  logic [3:0]  state;
  logic        Compute_done;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [10:0] led;

  modport master (output display_out, output state, output Compute_done,
                  input seg, input an, input led);
  modport slave  (input display_out, input state, input Compute_done,
                  output seg, output an, output led);
endinterface

// File: rtl/hex_to_sevenseg.sv
// Combinational hex digit to active-low seven-segment decoder with blanking.
module hex_to_sevenseg
  import tm_display_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg
);

  // Look up the glyph, or turn every segment off when blanked
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = HEX_GLYPH[code];
    end
  end

endmodule

// File: rtl/tm_display_driver.sv
// Multiplexed 4-digit display and tape-LED driver for the Turing-machine core.
// Digit 0: controller state, digit 1: 'd' when done, digits 2/3: decimal count
// of set tape cells. Inputs are sampled once per full scan so that every digit
// of a scan belongs to the same sample; the head LED blinks while running.
module tm_display_driver
  import tm_display_pkg::*;
#(
  parameter int REFRESH_DIV = 4,
  parameter int BLINK_DIV   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] display_out,
  input  logic [3:0]  state,
  input  logic        Compute_done,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [10:0] led
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  logic [RW-1:0] refresh_cnt_r;
  digit_idx_t    digit_idx_r;
  logic [BW-1:0] blink_cnt_r;
  logic          blink_r;
  logic [10:0]   snap_do_r;
  logic [3:0]    snap_state_r;
  logic          snap_done_r;

  logic          refresh_tc_s;
  logic [3:0]    pop_s;
  logic          tens_s;
  logic [3:0]    ones_s;
  logic [3:0]    code_s;
  logic          blank_s;
  logic [3:0]    an_s;
  logic [6:0]    seg_s;
  logic [10:0]   led_s;

  assign refresh_tc_s = (refresh_cnt_r == REFRESH_LAST);

  // Refresh divider, digit scan, blink divider and once-per-scan input snapshot
  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt_r <= '0;
      digit_idx_r   <= 2'd0;
      blink_cnt_r   <= '0;
      blink_r       <= 1'b0;
      snap_do_r     <= 11'd0;
      snap_state_r  <= 4'd0;
      snap_done_r   <= 1'b0;
    end else if (refresh_tc_s) begin
      refresh_cnt_r <= '0;
      digit_idx_r   <= digit_idx_r + 2'd1;
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= '0;
        blink_r     <= ~blink_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BW'(1);
      end
      if (digit_idx_r == DIGIT_LAST) begin
        snap_do_r    <= display_out;
        snap_state_r <= state;
        snap_done_r  <= Compute_done;
      end
    end else begin
      refresh_cnt_r <= refresh_cnt_r + RW'(1);
    end
  end

  // Pick the code, blanking and anode for the current digit; build the LED image
  always_comb begin
    pop_s   = popcount11(snap_do_r);
    tens_s  = (pop_s >= 4'd10);
    ones_s  = tens_s ? (pop_s - 4'd10) : pop_s;
    code_s  = 4'h0;
    blank_s = 1'b1;
    an_s    = 4'b1111;
    case (digit_idx_r)
      2'd0: begin
        code_s  = snap_state_r;
        blank_s = 1'b0;
        an_s    = 4'b1110;
      end
      2'd1: begin
        code_s  = 4'hD;
        blank_s = ~snap_done_r;
        an_s    = 4'b1101;
      end
      2'd2: begin
        code_s  = ones_s;
        blank_s = 1'b0;
        an_s    = 4'b1011;
      end
      2'd3: begin
        code_s  = {3'b000, tens_s};
        blank_s = ~tens_s;
        an_s    = 4'b0111;
      end
      default: begin
        code_s  = 4'h0;
        blank_s = 1'b1;
        an_s    = 4'b1111;
      end
    endcase
    led_s    = snap_do_r;
    led_s[5] = snap_do_r[5] ^ (blink_r & ~snap_done_r);
  end

  hex_to_sevenseg u_decode (
    .code  (code_s),
    .blank (blank_s),
    .seg   (seg_s)
  );

  // Registered outputs, forced dark while in reset
  always_ff @(posedge clock) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      led <= 11'd0;
    end else begin
      an  <= an_s;
      seg <= seg_s;
      led <= led_s;
    end
  end

endmodule

// File: tb/tb_tm_display_driver.sv
// Scoreboard bench for tm_display_driver: each scan pushes the four digits it
// expects, the monitor pops one entry whenever the active anode changes.
module tb_tm_display_driver;

  typedef struct packed {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [10:0] led;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  tm_display_if dif();

  tm_display_driver #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .display_out  (dif.display_out),
    .state        (dif.state),
    .Compute_done (dif.Compute_done),
    .seg          (dif.seg),
    .an           (dif.an),
    .led          (dif.led)
  );

  always #5 clock = ~clock;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          scan_idx = 0;
  logic [6:0]  glyph [16];
  logic [10:0] snap_do;
  logic [3:0]  snap_st;
  logic        snap_dn;
  logic [3:0]  prev_an = 4'hF;
  int          hold = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // count rising edges since reset release
  always @(posedge clock) begin
    if (reset) cyc = 0;
    else cyc = cyc + 1;
  end

  // monitor: a new anode value starts a digit period
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_an = 4'hF;
      hold = 0;
    end else begin
      if (dif.an !== prev_an) begin
        if (prev_an != 4'hF) check_eq("hold", hold, 4);
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          check_eq("an", dif.an, e.an);
          check_eq("seg", dif.seg, e.seg);
          check_eq("led", dif.led, e.led);
        end
        hold = 1;
      end else begin
        hold++;
      end
      prev_an = dif.an;
    end
  end

  task automatic push_scan();
    exp_t e;
    int pc, n;
    pc = $countones(snap_do);
    for (int d = 0; d < 4; d++) begin
      n = 4 * scan_idx + d;
      e.an = 4'hF;
      e.an[d] = 1'b0;
      case (d)
        0: e.seg = glyph[snap_st];
        1: e.seg = snap_dn ? 7'b0100001 : 7'h7F;
        2: e.seg = glyph[pc % 10];
        default: e.seg = (pc >= 10) ? glyph[pc / 10] : 7'h7F;
      endcase
      e.led = snap_do;
      if (!snap_dn && ((n / 8) % 2 == 1)) e.led[5] = ~e.led[5];
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (cyc != target && guard < 1000) begin
      @(negedge clock); #1;
      guard++;
    end
    if (cyc != target) check_eq("sync_timeout", cyc, target);
  endtask

  task automatic run_scan(input logic [10:0] d, input logic [3:0] st, input logic dn, input int chg);
    push_scan();
    wait_cyc(16 * scan_idx + chg);
    dif.display_out = d;
    dif.state = st;
    dif.Compute_done = dn;
    wait_cyc(16 * (scan_idx + 1));
    snap_do = d; snap_st = st; snap_dn = dn;
    scan_idx++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
    glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
    glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;

    reset = 1'b1;
    dif.display_out = 11'h000;
    dif.state = 4'h0;
    dif.Compute_done = 1'b0;

    // reset held three cycles: outputs dark
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("rst_an", dif.an, 4'hF);
      check_eq("rst_seg", dif.seg, 7'h7F);
      check_eq("rst_led", dif.led, 11'h000);
    end
    #1 reset = 1'b0;
    snap_do = 11'h000; snap_st = 4'h0; snap_dn = 1'b0; scan_idx = 0;

    run_scan(11'h020, 4'h3, 1'b0, 2);  // zeroed snapshot shown
    run_scan(11'h7FF, 4'hA, 1'b1, 2);  // shows 3,blank,1,blank
    run_scan(11'h020, 4'h3, 1'b0, 2);  // shows A,d,1,1 with steady head LED
    run_scan(11'h020, 4'h3, 1'b0, 2);  // blinking head LED
    run_scan(11'h000, 4'h7, 1'b0, 2);
    run_scan(11'h3FF, 4'hF, 1'b1, 5);  // change while digit 1 is active
    run_scan(11'h155, 4'hC, 1'b0, 2);  // shows F,d,0,1
    run_scan(11'h0FF, 4'h9, 1'b1, 2);  // shows C,blank,5,blank

    // reset while digit 2 is displayed
    push_scan();
    wait_cyc(16 * scan_idx + 9);
    reset = 1'b1;
    @(negedge clock);
    check_eq("mid_rst_an", dif.an, 4'hF);
    check_eq("mid_rst_seg", dif.seg, 7'h7F);
    check_eq("mid_rst_led", dif.led, 11'h000);
    check_eq("mid_rst_pending", sb_q.size(), 1);
    sb_q.delete();
    @(negedge clock); #1;
    reset = 1'b0;
    snap_do = 11'h000; snap_st = 4'h0; snap_dn = 1'b0; scan_idx = 0;

    run_scan(11'h0FF, 4'h9, 1'b1, 2);  // snapshot cleared: 0,blank,0,blank
    run_scan(11'h000, 4'h0, 1'b0, 2);  // shows 9,d,8,blank
    check_eq("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
